// File: rtl/iseq_pkg.sv
// iseq_pkg: shared types, vector constants and bus-control decode for the
// interrupt sequencer. Optional WAI support (WAIT state) is compiled in only
// when ISEQ_WAI_EN is defined.
package iseq_pkg;

    // Source of the sequence currently being run.
    typedef enum logic [1:0] {
        ISRC_RST = 2'd0,
        ISRC_NMI = 2'd1,
        ISRC_BRK = 2'd2,
        ISRC_IRQ = 2'd3
    } isrc_t;

    // Which byte goes onto the stack during a push cycle.
    typedef enum logic [1:0] {
        PSEL_PCH  = 2'd0,
        PSEL_PCL  = 2'd1,
        PSEL_PSR  = 2'd2,
        PSEL_NONE = 2'd3
    } psel_t;

    // Sequencer states; WAIT exists only in the WAI-enabled build.
`ifdef ISEQ_WAI_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1,
        ST_WAIT = 2'd2
    } iseq_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1
    } iseq_state_t;
`endif

    // Low-byte vector addresses; the high byte lives at the next address.
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;  // shared by BRK and IRQ

    // Step numbers with a specific bus role.
    localparam logic [2:0] STEP_PUSH_PCH = 3'd2;
    localparam logic [2:0] STEP_PUSH_PCL = 3'd3;
    localparam logic [2:0] STEP_PUSH_PSR = 3'd4;
    localparam logic [2:0] STEP_VEC_LO   = 3'd5;
    localparam logic [2:0] STEP_VEC_HI   = 3'd6;
    localparam logic [2:0] STEP_LAST     = 3'd6;

    // Everything the sequencer drives onto the bus/datapath in one cycle.
    typedef struct packed {
        logic        rwb;
        logic        sp_decrement;
        psel_t       push_sel;
        logic        b_out;
        logic        vpb;
        logic [15:0] vector_addr;
        logic        load_pcl;
        logic        load_pch;
        logic        set_i;
        logic        clear_d;
    } bus_ctl_t;

    // Vector low-byte address for a given source.
    function automatic logic [15:0] vector_base(isrc_t src);
        logic [15:0] v;
        case (src)
            ISRC_NMI: v = VEC_NMI;
            ISRC_RST: v = VEC_RST;
            default:  v = VEC_IRQ;
        endcase
        return v;
    endfunction

    // Bus controls while no sequence is running.
    function automatic bus_ctl_t idle_ctl();
        bus_ctl_t c;
        c.rwb          = 1'b1;
        c.sp_decrement = 1'b0;
        c.push_sel     = PSEL_NONE;
        c.b_out        = 1'b0;
        c.vpb          = 1'b1;
        c.vector_addr  = 16'h0000;
        c.load_pcl     = 1'b0;
        c.load_pch     = 1'b0;
        c.set_i        = 1'b0;
        c.clear_d      = 1'b0;
        return c;
    endfunction

    // Bus controls for a given sequence position. Reset runs the push steps
    // as dummy reads: the stack pointer still moves but nothing is written.
    function automatic bus_ctl_t step_ctl(logic active, logic [2:0] step, isrc_t src);
        bus_ctl_t c;
        c = idle_ctl();
        if (active) begin
            c.b_out = (src == ISRC_BRK);
            case (step)
                STEP_PUSH_PCH: c.push_sel = PSEL_PCH;
                STEP_PUSH_PCL: c.push_sel = PSEL_PCL;
                STEP_PUSH_PSR: c.push_sel = PSEL_PSR;
                default:       c.push_sel = PSEL_NONE;
            endcase
            if (step >= STEP_PUSH_PCH && step <= STEP_PUSH_PSR) begin
                c.sp_decrement = 1'b1;
                c.rwb          = (src == ISRC_RST);
            end
            if (step == STEP_VEC_LO) begin
                c.vpb         = 1'b0;
                c.vector_addr = vector_base(src);
                c.load_pcl    = 1'b1;
                c.set_i       = 1'b1;
                c.clear_d     = 1'b1;
            end
            if (step == STEP_VEC_HI) begin
                c.vpb         = 1'b0;
                c.vector_addr = vector_base(src) | 16'h0001;
                c.load_pch    = 1'b1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// nmi_edge_det: samples nmib on every falling edge of phi2 (independent of
// rdy) and latches a pending flag on a 1->0 change between two consecutive
// samples. A fresh edge wins over a simultaneous clear so it is never lost.
module nmi_edge_det (
    input  logic phi2_i,
    input  logic resb_i,
    input  logic nmib_i,
    input  logic clr_i,
    output logic pending_o
);

    logic nmib_q;
    logic pending_q;
    logic pending_d;
    logic fall;

    // The reset value of the sample is 0 so the first sample after reset can
    // never look like a falling edge.
    assign fall = nmib_q & ~nmib_i;

    // Pending latch: set by an edge, cleared when the NMI sequence is entered.
    always_comb begin
        pending_d = pending_q;
        if (fall) begin
            pending_d = 1'b1;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    // Sampler and pending flag update on the falling clock edge.
    always_ff @(negedge phi2_i or negedge resb_i) begin
        if (!resb_i) begin
            nmib_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            nmib_q    <= nmib_i;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: runs the 7-step reset/NMI/BRK/IRQ entry sequence
// (two internal cycles, three stack pushes, two vector fetches). State moves
// on the falling edge of phi2; rdy=0 freezes everything except NMI sampling.
// Define ISEQ_WAI_EN to add the wai_req input and the WAIT state.
//
// Handshake: a sequence starts only from IDLE at an edge where rdy=1 and
// either a reset is pending or inst_boundary=1 with a qualifying source;
// seq_done is high for exactly one rdy=1 cycle after step 6.
module interrupt_sequencer
    import iseq_pkg::*;
(
    input  logic        phi2,
    input  logic        resb,
    input  logic        nmib,
    input  logic        irqb,
    input  logic        rdy,
    input  logic        inst_boundary,
    input  logic        brk_req,
    input  logic        i_flag,
`ifdef ISEQ_WAI_EN
    input  logic        wai_req,
`endif
    output logic        seq_active,
    output logic [2:0]  seq_step,
    output logic [1:0]  seq_src,
    output logic        rwb,
    output logic        sp_decrement,
    output logic [1:0]  push_sel,
    output logic        b_out,
    output logic        vpb,
    output logic [15:0] vector_addr,
    output logic        load_pcl,
    output logic        load_pch,
    output logic        set_i,
    output logic        clear_d,
    output logic        seq_done
);

    iseq_state_t state_q, state_d;
    logic [2:0]  step_q, step_d;
    isrc_t       src_q, src_d;
    logic        rst_pending_q, rst_pending_d;
    logic        done_q, done_d;
    bus_ctl_t    ctl_q;

    logic        nmi_pending;
    logic        nmi_clr;
    logic        irq_take;

    nmi_edge_det u_nmi (
        .phi2_i   (phi2),
        .resb_i   (resb),
        .nmib_i   (nmib),
        .clr_i    (nmi_clr),
        .pending_o(nmi_pending)
    );

    // IRQ is a level: it only counts while irqb is low and not masked.
    assign irq_take = ~irqb & ~i_flag;

    // Next-state selection: start priority, step advance and WAIT exits.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        src_d         = src_q;
        rst_pending_d = rst_pending_q;
        done_d        = done_q;
        nmi_clr       = 1'b0;
        if (rdy) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rst_pending_q) begin
                        state_d       = ST_SEQ;
                        step_d        = 3'd0;
                        src_d         = ISRC_RST;
                        rst_pending_d = 1'b0;
                    end else if (inst_boundary) begin
                        if (nmi_pending) begin
                            state_d = ST_SEQ;
                            step_d  = 3'd0;
                            src_d   = ISRC_NMI;
                            nmi_clr = 1'b1;
                        end else if (brk_req) begin
                            state_d = ST_SEQ;
                            step_d  = 3'd0;
                            src_d   = ISRC_BRK;
                        end else if (irq_take) begin
                            state_d = ST_SEQ;
                            step_d  = 3'd0;
                            src_d   = ISRC_IRQ;
`ifdef ISEQ_WAI_EN
                        end else if (wai_req) begin
                            state_d = ST_WAIT;
                            step_d  = 3'd0;
`endif
                        end
                    end
                end
                ST_SEQ: begin
                    if (step_q == STEP_LAST) begin
                        state_d = ST_IDLE;
                        step_d  = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
`ifdef ISEQ_WAI_EN
                ST_WAIT: begin
                    if (nmi_pending) begin
                        state_d = ST_SEQ;
                        step_d  = 3'd0;
                        src_d   = ISRC_NMI;
                        nmi_clr = 1'b1;
                    end else if (irq_take) begin
                        state_d = ST_SEQ;
                        step_d  = 3'd0;
                        src_d   = ISRC_IRQ;
                    end else if (!irqb) begin
                        // Masked IRQ just resumes execution without vectoring.
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                end
            endcase
        end
    end

    // State and registered bus controls; controls are decoded from the next
    // state so they line up with seq_step and hold whenever rdy=0.
    always_ff @(negedge phi2 or negedge resb) begin
        if (!resb) begin
            state_q       <= ST_IDLE;
            step_q        <= 3'd0;
            src_q         <= ISRC_RST;
            rst_pending_q <= 1'b1;
            done_q        <= 1'b0;
            ctl_q         <= idle_ctl();
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            src_q         <= src_d;
            rst_pending_q <= rst_pending_d;
            done_q        <= done_d;
            ctl_q         <= step_ctl(state_d == ST_SEQ, step_d, src_d);
        end
    end

    assign seq_active   = (state_q == ST_SEQ);
    assign seq_step     = seq_active ? step_q : 3'd0;
    assign seq_src      = seq_active ? src_q : ISRC_RST;
    assign seq_done     = done_q;
    assign rwb          = ctl_q.rwb;
    assign sp_decrement = ctl_q.sp_decrement;
    assign push_sel     = ctl_q.push_sel;
    assign b_out        = ctl_q.b_out;
    assign vpb          = ctl_q.vpb;
    assign vector_addr  = ctl_q.vector_addr;
    assign load_pcl     = ctl_q.load_pcl;
    assign load_pch     = ctl_q.load_pch;
    assign set_i        = ctl_q.set_i;
    assign clear_d      = ctl_q.clear_d;

endmodule
